// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory-side controller: FSM state encoding and default sizing.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_RESP  = 2'd3
  } mc_state_t;

  localparam int MC_BYTES_DEFAULT  = 8;
  localparam int MC_DATA_W_DEFAULT = MC_BYTES_DEFAULT * 8;

endpackage

// File: rtl/mem_ctrl_if.sv
// Core request/response channel plus the single-outstanding memory port.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BYTES-1:0]  req_wmask;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BYTES-1:0]  mem_wmask;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, mem_rdata, mem_resp,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
  );

  // Core and memory side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, mem_rdata, mem_resp,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/mem_ctrl_wdog.sv
// Transaction watchdog: counts strobe cycles since accept and flags expiry at TIMEOUT_CYCLES-1.
module mem_ctrl_wdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT; the FSM leaves the strobe state on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == LIMIT);

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding memory controller between the core FSM and a variable-latency memory port.
// Optional watchdog abort of hung transactions is enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = MC_DATA_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  localparam int              BYTES      = DATA_W / 8;
  localparam int              OFF_W      = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  mc_state_t         state;
  mc_state_t         state_next;
  logic              accept;
  logic              expired;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BYTES-1:0]  wmask;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A real completion takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      MC_IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = bus.req_we ? MC_WRITE : MC_READ;
        end
      end
      MC_READ, MC_WRITE: begin
        if (bus.mem_resp || expired) begin
          state_next = MC_RESP;
        end
      end
      MC_RESP: state_next = MC_IDLE;
      default: state_next = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      wdata <= '0;
      wmask <= '0;
      rdata <= '0;
    end else begin
      if (accept) begin
        addr  <= bus.req_addr & ALIGN_MASK;
        wdata <= bus.req_wdata;
        wmask <= bus.req_we ? bus.req_wmask : '0;
        rdata <= '0;
      end
      if ((state == MC_READ) && bus.mem_resp) begin
        rdata <= bus.mem_rdata;
      end
    end
  end

`ifdef MEM_CTRL_TIMEOUT_EN
  logic err;

  mem_ctrl_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .run    ((state == MC_READ) || (state == MC_WRITE)),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (expired && !bus.mem_resp) begin
      err <= 1'b1;
    end
  end

  assign bus.resp_err = (state == MC_RESP) && err;
`else
  assign expired      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  // All outputs decode directly from flops, so an async reset clears them at once.
  assign bus.req_ready  = (state == MC_IDLE);
  assign bus.mem_read   = (state == MC_READ);
  assign bus.mem_write  = (state == MC_WRITE);
  assign bus.mem_addr   = addr;
  assign bus.mem_wdata  = wdata;
  assign bus.mem_wmask  = wmask;
  assign bus.resp_valid = (state == MC_RESP);
  assign bus.resp_rdata = (state == MC_RESP) ? rdata : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Table-driven bench for mem_ctrl with a scoreboard of expected responses and a latency-programmable memory model.
module tb_mem_ctrl;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 8;
`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // lat = number of strobe cycles before mem_resp; 0 = memory never answers
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wmask;
    int            lat;
    logic [DW-1:0] mdata;
    logic [AW-1:0] exp_addr;
    logic [BW-1:0] exp_wmask;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            strobes;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            strobes;
    int            acc;
  } sb_t;

  vec_t vecs[$];
  vec_t strm[$];
  vec_t mq[$];
  sb_t  sb[$];
  int   acc_hist[$];
  vec_t drv;
  vec_t act;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_count = 0;
  int resp_count = 0;
  int cnt = 0;
  int last_strobes = 0;
  bit in_txn = 1'b0;
  bit spur = 1'b0;

  function automatic vec_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [BW-1:0] wmask, input int lat, input logic [DW-1:0] mdata,
                              input logic [AW-1:0] exp_addr, input logic [BW-1:0] exp_wmask,
                              input logic [DW-1:0] exp_rdata, input logic exp_err, input int strobes);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.wmask = wmask; v.lat = lat; v.mdata = mdata;
    v.exp_addr = exp_addr; v.exp_wmask = exp_wmask; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.strobes = strobes;
    return v;
  endfunction

  function automatic void chk(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] req);
    checks++;
    if (actual !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, actual, req, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model, protocol monitor and scoreboard, sampled mid-low-phase.
  always @(negedge clk) begin
    #2;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = {$urandom, $urandom};
    if (rst) begin
      in_txn = 1'b0;
    end else begin
      chk("strobe_exclusive", 64'(bus.mem_read && bus.mem_write), 64'd0);
      if (bus.mem_read || bus.mem_write) begin
        if (!in_txn) begin
          if (mq.size() == 0) begin
            chk("strobe_without_accept", 64'd1, 64'd0);
            act = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
          end else begin
            act = mq.pop_front();
          end
          in_txn = 1'b1;
          cnt    = 0;
        end
        cnt++;
        chk("strobe_kind", 64'(bus.mem_write), 64'(act.we));
        chk("mem_addr", 64'(bus.mem_addr), 64'(act.exp_addr));
        chk("mem_wmask", 64'(bus.mem_wmask), 64'(act.exp_wmask));
        if (act.we) chk("mem_wdata", bus.mem_wdata, act.wdata);
        chk("ready_low_busy", 64'(bus.req_ready), 64'd0);
        if (act.lat != 0 && cnt == act.lat) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = act.mdata;
        end
      end else begin
        if (in_txn) last_strobes = cnt;
        in_txn       = 1'b0;
        bus.mem_resp = spur;
      end

      if (bus.resp_valid) begin
        resp_count++;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", 64'(bus.resp_err), 64'(e.err));
          chk("resp_delay", 64'(cyc - e.acc), 64'(e.strobes + 1));
          chk("strobe_cycles", 64'(last_strobes), 64'(e.strobes));
        end
      end else begin
        chk("idle_rdata_zero", bus.resp_rdata, 64'd0);
        chk("idle_err_zero", 64'(bus.resp_err), 64'd0);
      end

      if (bus.req_valid && bus.req_ready) begin
        sb_t e;
        e.rdata = drv.exp_rdata; e.err = drv.exp_err; e.strobes = drv.strobes; e.acc = cyc;
        sb.push_back(e);
        mq.push_back(drv);
        acc_hist.push_back(cyc);
        acc_count++;
      end
    end
  end

  task automatic drive(input vec_t v);
    drv           = v;
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_wmask = v.wmask;
  endtask

  task automatic wait_accept(input int prev);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (acc_count != prev) return;
    end
    chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic send(input vec_t v);
    int prev;
    @(negedge clk);
    prev = acc_count;
    drive(v);
    wait_accept(prev);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && mq.size() == 0 && bus.req_ready) return;
    end
    chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 64'd0);
    chk({tag, "_resp_err"}, 64'(bus.resp_err), 64'd0);
    chk({tag, "_mem_read"}, 64'(bus.mem_read), 64'd0);
    chk({tag, "_mem_write"}, 64'(bus.mem_write), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 64'd0);
    chk({tag, "_mem_wmask"}, 64'(bus.mem_wmask), 64'd0);
  endtask

  initial begin
    int rc;
    int base;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    drv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs.push_back(mk(0, 32'h1004, 64'h5555_5555_5555_5555, 8'hFF, 4, 64'hDEAD_BEEF_0000_1111,
                      32'h1000, 8'h00, 64'hDEAD_BEEF_0000_1111, 0, 4));
    vecs.push_back(mk(1, 32'h20, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1, 64'h1234,
                      32'h20, 8'h0F, 64'h0, 0, 1));
    vecs.push_back(mk(1, 32'h37, 64'h0102_0304_0506_0708, 8'hF0, 3, 64'h9999,
                      32'h30, 8'hF0, 64'h0, 0, 3));
    vecs.push_back(mk(0, 32'hFFFF_FFFF, 64'h0, 8'h00, 2, 64'h0123_4567_89AB_CDEF,
                      32'hFFFF_FFF8, 8'h00, 64'h0123_4567_89AB_CDEF, 0, 2));
    vecs.push_back(mk(0, 32'h8, 64'h0, 8'h3C, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                      32'h8, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1));
`ifdef MEM_CTRL_TIMEOUT_EN
    vecs.push_back(mk(0, 32'h100, 64'h0, 8'h00, 0, 64'h77, 32'h100, 8'h00, 64'h0, 1, 16));
    vecs.push_back(mk(1, 32'h104, 64'h55, 8'h03, 0, 64'h0, 32'h100, 8'h03, 64'h0, 1, 16));
    vecs.push_back(mk(0, 32'h108, 64'h0, 8'h00, 16, 64'hCAFE, 32'h108, 8'h00, 64'hCAFE, 0, 16));
`else
    vecs.push_back(mk(0, 32'h4000, 64'h0, 8'h00, 1000, 64'hFEED_F00D_0000_0001,
                      32'h4000, 8'h00, 64'hFEED_F00D_0000_0001, 0, 1000));
`endif

    strm.push_back(mk(0, 32'h200, 64'h0, 8'h00, 2, 64'h1111, 32'h200, 8'h00, 64'h1111, 0, 2));
    strm.push_back(mk(1, 32'h20C, 64'h2222, 8'h0F, 1, 64'h0, 32'h208, 8'h0F, 64'h0, 0, 1));
    strm.push_back(mk(0, 32'h210, 64'h0, 8'h00, 1, 64'h3333, 32'h210, 8'h00, 64'h3333, 0, 1));
    strm.push_back(mk(1, 32'h218, 64'h4444, 8'hFF, 1, 64'h0, 32'h218, 8'hFF, 64'h0, 0, 1));

    // Reset state
    repeat (2) @(negedge clk);
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table of single transactions
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i]);
      wait_idle();
    end

    // req_valid held high across a read/write/read/write stream
    base = acc_hist.size();
    @(negedge clk);
    for (int i = 0; i < strm.size(); i++) begin
      rc = acc_count;
      drive(strm[i]);
      wait_accept(rc);
    end
    bus.req_valid = 1'b0;
    wait_idle();
    chk("stream_accepts", 64'(acc_hist.size() - base), 64'd4);
    if (acc_hist.size() - base == 4) begin
      chk("gap_read_l2", 64'(acc_hist[base+1] - acc_hist[base]), 64'd4);
      chk("gap_write_l1", 64'(acc_hist[base+2] - acc_hist[base+1]), 64'd3);
      chk("gap_read_l1", 64'(acc_hist[base+3] - acc_hist[base+2]), 64'd3);
    end

    // Spurious mem_resp while idle
    rc = resp_count;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("spurious_no_resp", 64'(resp_count), 64'(rc));
    chk("spurious_still_idle", 64'(bus.req_ready), 64'd1);

    // Reset in the middle of a read with the strobe up
    send(mk(0, 32'h2008, 64'h0, 8'h00, 0, 64'h0, 32'h2008, 8'h00, 64'h0, 0, 0));
    repeat (2) @(negedge clk);
    #4;
    chk("midrst_strobe_up", 64'(bus.mem_read), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    mq.delete();
    rc = resp_count;
    @(negedge clk);
    #4;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    chk("midrst_no_resp", 64'(resp_count), 64'(rc));
    send(mk(0, 32'h300F, 64'h0, 8'h00, 2, 64'hABCD_0123, 32'h3008, 8'h00, 64'hABCD_0123, 0, 2));
    wait_idle();
    chk("post_rst_resp", 64'(resp_count), 64'(rc + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
